uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clocks per serial bit; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte queue entries; power of two, 2..16.
REQ-003 SHALL have port i_Clock, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_Tx_DV, input, 1: write strobe for i_Tx_Byte.
REQ-006 SHALL have port i_Tx_Byte, input, 8: byte to transmit.
REQ-007 SHALL have port o_Tx_Ready, output, 1: high when the queue is not full.
REQ-008 SHALL have port o_Tx_Serial, output, 1: serial line; idle high.
REQ-009 SHALL have port o_Tx_Active, output, 1: high from the first start-bit cycle through the last stop-bit cycle.
REQ-010 SHALL have port o_Tx_Done, output, 1: single-cycle pulse after each stop bit completes.

Function
REQ-011 SHALL accept a byte on a rising edge where i_Tx_DV=1 and o_Tx_Ready=1; if o_Tx_Ready=0, SHALL drop the byte with no state change.
REQ-012 SHALL use the registered not-full flag for o_Tx_Ready, so a write while full is dropped even when a pop occurs in the same cycle.
REQ-013 SHALL send frames in order: 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1); all outputs SHALL be registered.
REQ-014 SHALL hold every bit on o_Tx_Serial for exactly CLKS_PER_BIT cycles, counted by a $clog2(CLKS_PER_BIT)-bit counter that resets to 0 at each bit boundary.
REQ-015 SHALL use states IDLE, START, DATA, STOP and CLEANUP (plus PARITY when configured).
REQ-016 SHALL handle IDLE: when the queue is non-empty, pop the head, load the shift register and go to START.
REQ-017 SHALL handle START and DATA: after CLKS_PER_BIT cycles in START go to DATA; after the 8th data bit go to STOP, or to PARITY when configured.
REQ-018 SHALL handle STOP and CLEANUP: after CLKS_PER_BIT cycles in STOP, pulse o_Tx_Done and go to CLEANUP; CLEANUP SHALL last 1 cycle with the line high, then go to IDLE.
REQ-019 SHALL meet the latency rule: a byte accepted at edge N into an idle, empty block drives the start bit on o_Tx_Serial from edge N+2.
REQ-020 SHALL separate back-to-back frames by exactly 2 idle-high cycles (CLEANUP + IDLE).
REQ-021 SHALL let the queue accept writes during transmission; a simultaneous push and pop on a non-full queue SHALL leave the count unchanged.
REQ-022 SHALL use pointers that wrap modulo FIFO_DEPTH.
REQ-023 SHALL NOT alter the frame in progress when i_Tx_Byte or i_Tx_DV change mid-frame.

Reset
REQ-024 SHALL, while i_Reset_n=0, immediately force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, state=IDLE, and counters, pointers and count to 0.
REQ-025 SHALL abort any frame in progress on reset and discard queued bytes; no partial frame SHALL resume after release.

Configuration
REQ-026 SHALL, when macro UART_TX_PARITY_EN is defined, insert one PARITY bit of CLKS_PER_BIT cycles between data bit 7 and the stop bit, equal to the XOR of the 8 data bits (even parity).
REQ-027 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or logic; frames are 10 bits.

Structure
REQ-028 SHALL take the state encoding (3-bit) and frame constants (data bits = 8, idle level = 1) from shared package uart_pkg, also usable by the receiver.
REQ-029 SHALL implement the queue as sub-module uart_tx_fifo (parameter FIFO_DEPTH; push, pop, data, full, empty).

Verification
REQ-030 SHALL verify single-byte framing: CLKS_PER_BIT=87, write 0x3C -> line 0,0,0,1,1,1,1,0,0,1, each bit 87 cycles, start bit at N+2, o_Tx_Done pulses once.
REQ-031 SHALL verify back-to-back frames: write 0x55 then 0xA3 on consecutive cycles -> two frames in order, exactly 2 high cycles between them, two o_Tx_Done pulses.
REQ-032 SHALL verify overflow: with FIFO_DEPTH=4, write 6 bytes 0x01..0x06 in consecutive cycles while idle -> o_Tx_Ready drops, 0x06 is dropped, and 0x01..0x05 are sent.
REQ-033 SHALL verify reset mid-frame: assert i_Reset_n=0 during data bit 3 of 0xFF with 2 bytes queued -> line high at once; after release, no frames and o_Tx_Ready=1.
REQ-034 SHALL verify parity: with UART_TX_PARITY_EN defined, 0x07 -> parity bit 1 and 0x3C -> parity bit 0; each frame is 11 bits of 87 cycles.
REQ-035 SHALL verify minimum divider: CLKS_PER_BIT=2, write 0x80 -> 10 bits of 2 cycles each, with bit 7 high in the 9th bit slot.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the transmitter (and any matching receiver):
// frame constants and the 3-bit serialiser state encoding.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> adds the PARITY state and the even-parity helper
//   undefined -> 10-bit frames, no parity state or logic
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS  = 8;     // payload bits per frame
    localparam logic IDLE_LEVEL = 1'b1;  // line level between frames / stop bit

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
        ,
        PARITY  = 3'd5
`endif
    } uart_state_e;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte queue in front of the UART serialiser.
//
// Ports:
//   clk_i    : rising-edge clock
//   rst_ni   : asynchronous active-low reset (empties the queue)
//   push_i   : write request; ignored while full_o is high
//   data_i   : byte to enqueue
//   pop_i    : read request; ignored while empty_o is high
//   data_o   : head of the queue (valid while empty_o is low)
//   full_o   : registered full flag
//   empty_o  : registered empty flag
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [PW:0]          count_q;
    logic [PW:0]          count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 push_ok;
    logic                 pop_ok;

    // Gating on the registered flags means a write while full is dropped even
    // if a pop frees a slot on the same edge.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i  && !empty_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;  // idle, or push+pop cancel out
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            // Power-of-two depth: pointers wrap modulo FIFO_DEPTH naturally.
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: the storage array has no reset; pointers and flags are reset, so an
    // entry is never read before it has been written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// UART transmitter with a byte queue. Frames: start(0), 8 data bits LSB first,
// [even parity], stop(1). Every bit lasts CLKS_PER_BIT clocks; consecutive
// frames are separated by two idle-high cycles (CLEANUP + IDLE).
//
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit, 2..255
//   FIFO_DEPTH   : queue entries, power of two, 2..16
// Ports:
//   i_Clock     : rising-edge clock
//   i_Reset_n   : asynchronous active-low reset; aborts frame, clears queue
//   i_Tx_DV     : write strobe for i_Tx_Byte (accepted when o_Tx_Ready=1)
//   i_Tx_Byte   : byte to transmit
//   o_Tx_Ready  : queue not full (registered)
//   o_Tx_Serial : serial line, idle high
//   o_Tx_Active : high from first start-bit cycle through last stop-bit cycle
//   o_Tx_Done   : one-cycle pulse in the cycle after each stop bit
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [CW-1:0]        clk_cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    // The serialiser pops only from IDLE; the byte is copied into shift_q so
    // later writes or input changes cannot disturb the frame in flight.
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset_n),
        .push_i  (i_Tx_DV),
        .data_i  (i_Tx_Byte),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs are registered from the current state, so the line follows the
    // state by one cycle: a pop at edge N+1 puts the start bit out at N+2.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= IDLE_LEVEL;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q  <= IDLE_LEVEL;
                    active_q  <= 1'b0;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!fifo_empty) begin
                        shift_q <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= even_parity(fifo_data);
`endif
                        state_q <= START;
                    end
                end
                START: begin
                    serial_q <= 1'b0;
                    active_q <= 1'b1;
                    if (clk_cnt_q == LAST_CNT) begin
                        clk_cnt_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    serial_q <= shift_q[bit_idx_q];
                    active_q <= 1'b1;
                    if (clk_cnt_q == LAST_CNT) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    serial_q <= parity_q;
                    active_q <= 1'b1;
                    if (clk_cnt_q == LAST_CNT) begin
                        clk_cnt_q <= '0;
                        state_q   <= STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    serial_q <= IDLE_LEVEL;
                    active_q <= 1'b1;
                    if (clk_cnt_q == LAST_CNT) begin
                        clk_cnt_q <= '0;
                        state_q   <= CLEANUP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                CLEANUP: begin
                    // First cycle after the stop bit: line high, Done pulse.
                    serial_q <= IDLE_LEVEL;
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    serial_q <= IDLE_LEVEL;
                    active_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Ready  = !fifo_full;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Two DUT instances share clock and reset: u_dut_a (CLKS_PER_BIT=87) and
// u_dut_b (CLKS_PER_BIT=2), both FIFO_DEPTH=4. Stimulus pushes the expected
// bytes into exp_q; a line monitor decodes each frame from the selected DUT,
// checks bit widths, Active/Done behaviour and pops exp_q to compare.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;
    logic       ready_a, ser_a, act_a, done_a;
    logic       ready_b, ser_b, act_b, done_b;
    logic       sel;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(87), .FIFO_DEPTH(4)) u_dut_a (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Tx_DV     (dv_a),
        .i_Tx_Byte   (byte_a),
        .o_Tx_Ready  (ready_a),
        .o_Tx_Serial (ser_a),
        .o_Tx_Active (act_a),
        .o_Tx_Done   (done_a)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut_b (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Tx_DV     (dv_b),
        .i_Tx_Byte   (byte_b),
        .o_Tx_Ready  (ready_b),
        .o_Tx_Serial (ser_b),
        .o_Tx_Active (act_b),
        .o_Tx_Done   (done_b)
    );

    wire mon_ser  = sel ? ser_b  : ser_a;
    wire mon_act  = sel ? act_b  : act_a;
    wire mon_done = sel ? done_b : done_a;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         frames_seen = 0;
    int         done_cnt = 0;
    int         idle_run = 0;
    int         last_gap = 0;
    time        t_start = 0;
    time        t_edge = 0;
    logic [10:0] last_frame = '0;
    bit         in_frame = 0;
    logic       last_ready;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference frame, bit i = line level in slot i.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Line monitor / scoreboard consumer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idle_run = 0;
            end else if (mon_ser !== 1'b0) begin
                idle_run++;
            end else begin
                automatic int          cpb = sel ? 2 : 87;
                automatic logic [10:0] got = '0;
                automatic int          bad = 0;
                automatic bit          aborted = 0;
                in_frame = 1;
                t_start  = $time;
                last_gap = idle_run;
                for (int k = 0; k < NB * cpb; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1;
                        break;
                    end
                    if (k % cpb == 0) got[k / cpb] = mon_ser;
                    else if (mon_ser !== got[k / cpb]) bad++;
                    if (mon_act !== 1'b1) bad++;
                    if (mon_done !== 1'b0) bad++;
                end
                in_frame = 0;
                if (!aborted) begin
                    @(negedge clk);
                    check("post_frame_done_act_line", {29'd0, mon_done, mon_act, mon_ser}, 32'b101);
                    check("bit_timing_errors", bad, 0);
                    check("frame_was_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("frame_bits", got, exp_frame(exp_q.pop_front()));
                    last_frame = got;
                    frames_seen++;
                    idle_run = 1;
                end else begin
                    idle_run = 0;
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        last_ready = sel ? ready_b : ready_a;
        if (sel) begin dv_b = 1'b1; byte_b = b; end
        else     begin dv_a = 1'b1; byte_a = b; end
        @(posedge clk);
        t_edge = $time;
    endtask

    task automatic end_writes();
        @(negedge clk);
        dv_a = 1'b0; dv_b = 1'b0;
        byte_a = 8'hEE; byte_b = 8'hEE;  // garbage on the bus must not matter
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_frame_count"}, frames_seen, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0;
        logic [5:0] rdy;

        rst_n = 1'b0; sel = 1'b0;
        dv_a = 1'b0; dv_b = 1'b0; byte_a = 8'h00; byte_b = 8'h00;
        #12;
        check("reset_state_a", {28'd0, ser_a, act_a, done_a, ready_a}, 32'b1001);
        check("reset_state_b", {28'd0, ser_b, act_b, done_b, ready_b}, 32'b1001);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x3C: start at N+2, one Done pulse.
        f0 = frames_seen; d0 = done_cnt;
        exp_q.push_back(8'h3C);
        write_byte(8'h3C);
        end_writes();
        wait_frames(f0 + 1, 2000, "single");
        check("single_start_latency", 32'(t_start - t_edge), 25);
`ifdef UART_TX_PARITY_EN
        check("single_hand_frame", last_frame, 11'b100_0111_1000);
`else
        check("single_hand_frame", last_frame, 11'b010_0111_1000);
`endif
        repeat (3) @(posedge clk);
        check("single_done_pulses", done_cnt - d0, 1);

        // Back-to-back 0x55, 0xA3.
        f0 = frames_seen; d0 = done_cnt;
        exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
        write_byte(8'h55);
        write_byte(8'hA3);
        end_writes();
        wait_frames(f0 + 2, 4000, "b2b");
        check("b2b_idle_gap", last_gap, 2);
`ifdef UART_TX_PARITY_EN
        check("b2b_hand_frame_a3", last_frame, 11'b101_0100_0110);
`else
        check("b2b_hand_frame_a3", last_frame, 11'b011_0100_0110);
`endif
        repeat (3) @(posedge clk);
        check("b2b_done_pulses", done_cnt - d0, 2);

        // Overflow: 6 writes into depth 4; 0x01 is popped, 0x02..0x05 fill it.
        f0 = frames_seen; d0 = done_cnt;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(i + 1));
            rdy[i] = last_ready;
        end
        end_writes();
        check("overflow_ready_pattern", rdy, 6'b011111);
        wait_frames(f0 + 5, 6000, "overflow");
        repeat (3) @(posedge clk);
        check("overflow_done_pulses", done_cnt - d0, 5);
        check("overflow_ready_after", ready_a, 1);

        // Reset during data bit 3 of 0xFF with 0x11, 0x22 queued.
        f0 = frames_seen;
        write_byte(8'hFF);
        write_byte(8'h11);
        write_byte(8'h22);
        end_writes();
        repeat (388) @(posedge clk);
        #2;
        check("reset_mid_frame_active_before", act_a, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame_outputs", {28'd0, ser_a, act_a, done_a, ready_a}, 32'b1001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #2;
        check("reset_no_frames_after", frames_seen, f0);
        check("reset_idle_after", {29'd0, ser_a, act_a, ready_a}, 32'b101);

        // Minimum divider on u_dut_b: 0x80, bit 7 in the 9th slot.
        @(negedge clk); sel = 1'b1;
        f0 = frames_seen; d0 = done_cnt;
        exp_q.push_back(8'h80);
        write_byte(8'h80);
        end_writes();
        wait_frames(f0 + 1, 200, "cpb2");
        check("cpb2_start_latency", 32'(t_start - t_edge), 25);
`ifdef UART_TX_PARITY_EN
        check("cpb2_hand_frame", last_frame, 11'b111_0000_0000);
`else
        check("cpb2_hand_frame", last_frame, 11'b011_0000_0000);
`endif
        repeat (3) @(posedge clk);
        check("cpb2_done_pulses", done_cnt - d0, 1);
        @(negedge clk); sel = 1'b0;

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 -> 1, 0x3C -> 0.
        f0 = frames_seen;
        exp_q.push_back(8'h07);
        write_byte(8'h07);
        end_writes();
        wait_frames(f0 + 1, 2000, "parity_07");
        check("parity_07_bit", last_frame[9], 1);
        exp_q.push_back(8'h3C);
        write_byte(8'h3C);
        end_writes();
        wait_frames(f0 + 2, 2000, "parity_3c");
        check("parity_3c_bit", last_frame[9], 0);
`endif

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
